// File: rtl/ecg_pkg.sv
// Shared types and helpers for the ECG R-peak detection chain.
package ecg_pkg;

  localparam int ECG_DATA_W = 16;
  localparam int ECG_IDX_W  = 16;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_TRACK   = 2'd1,
    ST_REFRACT = 2'd2
  } state_e;

  // Magnitude of a signed sample; the most negative code saturates to max positive.
  function automatic logic [ECG_DATA_W-1:0] sat_abs(input logic signed [ECG_DATA_W-1:0] v);
    logic [ECG_DATA_W-1:0] r;
    if (v == {1'b1, {(ECG_DATA_W-1){1'b0}}}) begin
      r = {1'b0, {(ECG_DATA_W-1){1'b1}}};
    end else if (v[ECG_DATA_W-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mwi_integrator.sv
// Rectifies the filtered stream and averages it over a sliding power-of-two window.
module mwi_integrator
  import ecg_pkg::*;
#(
  parameter int DATA_W   = ECG_DATA_W,
  parameter int WIN_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] y,
  output logic        [DATA_W-1:0] mwi,
  output logic                     mwi_valid
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_W + WIN_LOG2;

  logic [DATA_W-1:0]   win_q [DEPTH];
  logic [WIN_LOG2-1:0] wp_q, wp_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   mwi_q, mwi_d;
  logic                mwi_valid_q, mwi_valid_d;
  logic [DATA_W-1:0]   a_s;

  // Running sum swaps the oldest window entry for the new magnitude.
  always_comb begin
    a_s         = sat_abs(y);
    sum_d       = sum_q;
    wp_d        = wp_q;
    mwi_d       = mwi_q;
    mwi_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum_q + SUM_W'(a_s) - SUM_W'(win_q[wp_q]);
      wp_d        = wp_q + 1'b1;
      mwi_d       = sum_d[SUM_W-1:WIN_LOG2];
      mwi_valid_d = 1'b1;
    end else begin
      sum_d       = sum_q;
      mwi_valid_d = 1'b0;
    end
  end

  // Window storage, pointer, sum and registered average.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= {DATA_W{1'b0}};
      wp_q        <= {WIN_LOG2{1'b0}};
      sum_q       <= {SUM_W{1'b0}};
      mwi_q       <= {DATA_W{1'b0}};
      mwi_valid_q <= 1'b0;
    end else begin
      if (in_valid) win_q[wp_q] <= a_s;
      wp_q        <= wp_d;
      sum_q       <= sum_d;
      mwi_q       <= mwi_d;
      mwi_valid_q <= mwi_valid_d;
    end
  end

  assign mwi       = mwi_q;
  assign mwi_valid = mwi_valid_q;

endmodule

// File: rtl/ecg_peak_detector.sv
// Threshold/refractory R-peak detector on top of the moving-window integrator.
module ecg_peak_detector
  import ecg_pkg::*;
#(
  parameter int DATA_W   = ECG_DATA_W,
  parameter int WIN_LOG2 = 3,
  parameter int REFRACT  = 40,
  parameter int IDX_W    = ECG_IDX_W
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] y,
  input  logic        [DATA_W-1:0] thresh,
  output logic        [DATA_W-1:0] mwi,
  output logic                     mwi_valid,
  output logic                     peak_valid,
  output logic        [DATA_W-1:0] peak_amp,
  output logic        [IDX_W-1:0]  rr_interval,
  output logic                     first_peak
);

  localparam int CNT_W = $clog2(REFRACT + 1);

  mwi_integrator #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) u_mwi (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .y         (y),
    .mwi       (mwi),
    .mwi_valid (mwi_valid)
  );

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] cand_amp_q, cand_amp_d;
  logic [IDX_W-1:0]  cand_idx_q, cand_idx_d;
  logic [IDX_W-1:0]  last_idx_q, last_idx_d;
  logic              armed_q, armed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              peak_valid_q, peak_valid_d;
  logic [DATA_W-1:0] peak_amp_q, peak_amp_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              first_peak_q, first_peak_d;
  logic [IDX_W-1:0]  cur_idx_s;
  logic [DATA_W-1:0] best_amp_s;
  logic [IDX_W-1:0]  best_idx_s;

  // The mwi on the bus belongs to the most recently accepted sample.
  assign cur_idx_s = idx_q - 1'b1;

  // Sample index plus peak FSM; strict '>' keeps the earliest sample on ties.
  always_comb begin
    idx_d        = in_valid ? idx_q + 1'b1 : idx_q;
    state_d      = state_q;
    cand_amp_d   = cand_amp_q;
    cand_idx_d   = cand_idx_q;
    last_idx_d   = last_idx_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    peak_valid_d = 1'b0;
    peak_amp_d   = peak_amp_q;
    rr_d         = rr_q;
    first_peak_d = 1'b0;
    best_amp_s   = (mwi > cand_amp_q) ? mwi : cand_amp_q;
    best_idx_s   = (mwi > cand_amp_q) ? cur_idx_s : cand_idx_q;
    if (mwi_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (mwi > thresh) begin
            state_d    = ST_TRACK;
            cand_amp_d = mwi;
            cand_idx_d = cur_idx_s;
          end else begin
            state_d = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          cand_amp_d = best_amp_s;
          cand_idx_d = best_idx_s;
          if (mwi <= thresh) begin
            peak_valid_d = 1'b1;
            peak_amp_d   = best_amp_s;
            rr_d         = armed_q ? {IDX_W{1'b0}} : best_idx_s - last_idx_q;
            first_peak_d = armed_q;
            last_idx_d   = best_idx_s;
            armed_d      = 1'b0;
            cnt_d        = {CNT_W{1'b0}};
            state_d      = ST_REFRACT;
          end else begin
            state_d = ST_TRACK;
          end
        end
        ST_REFRACT: begin
          if (cnt_q == CNT_W'(REFRACT - 1)) begin
            state_d = ST_SEARCH;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state, candidate tracking and registered peak report.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_SEARCH;
      idx_q        <= {IDX_W{1'b0}};
      cand_amp_q   <= {DATA_W{1'b0}};
      cand_idx_q   <= {IDX_W{1'b0}};
      last_idx_q   <= {IDX_W{1'b0}};
      armed_q      <= 1'b1;
      cnt_q        <= {CNT_W{1'b0}};
      peak_valid_q <= 1'b0;
      peak_amp_q   <= {DATA_W{1'b0}};
      rr_q         <= {IDX_W{1'b0}};
      first_peak_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cand_amp_q   <= cand_amp_d;
      cand_idx_q   <= cand_idx_d;
      last_idx_q   <= last_idx_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      peak_valid_q <= peak_valid_d;
      peak_amp_q   <= peak_amp_d;
      rr_q         <= rr_d;
      first_peak_q <= first_peak_d;
    end
  end

  assign peak_valid  = peak_valid_q;
  assign peak_amp    = peak_amp_q;
  assign rr_interval = rr_q;
  assign first_peak  = first_peak_q;

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Directed bench for ecg_peak_detector: integrator ramps, peak reporting, refractory, gaps, reset.
module tb_ecg_peak_detector;

  logic               clk;
  logic               rstN;
  logic               in_valid;
  logic signed [15:0] y;
  logic        [15:0] thresh;
  logic        [15:0] mwi;
  logic               mwi_valid;
  logic               peak_valid;
  logic        [15:0] peak_amp;
  logic        [15:0] rr_interval;
  logic               first_peak;

  int n_chk = 0;
  int n_err = 0;
  bit gap_mode = 1'b0;

  logic [15:0] pk_amp[$];
  logic [15:0] pk_rr[$];
  logic        pk_first[$];
  logic        pk_pre[$];
  logic        pre_valid = 1'b0;
  logic [15:0] pre_mwi = 16'd0;

  ecg_peak_detector #(.DATA_W(16), .WIN_LOG2(3), .REFRACT(40), .IDX_W(16)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .in_valid    (in_valid),
    .y           (y),
    .thresh      (thresh),
    .mwi         (mwi),
    .mwi_valid   (mwi_valid),
    .peak_valid  (peak_valid),
    .peak_amp    (peak_amp),
    .rr_interval (rr_interval),
    .first_peak  (first_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peak log; pre_* remember the previous cycle to confirm one-cycle latency after mwi=1000.
  always @(negedge clk) begin
    if (peak_valid) begin
      pk_amp.push_back(peak_amp);
      pk_rr.push_back(rr_interval);
      pk_first.push_back(first_peak);
      pk_pre.push_back(pre_valid && (pre_mwi == 16'd1000));
    end
    pre_valid <= mwi_valid;
    pre_mwi   <= mwi;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] v, output logic [15:0] m);
    @(negedge clk);
    in_valid = 1'b1;
    y        = v;
    @(posedge clk);
    #1;
    chk("mwi_valid", {31'd0, mwi_valid}, 32'd1);
    m = mwi;
    if (gap_mode) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("gap_no_valid", {31'd0, mwi_valid}, 32'd0);
    end
  endtask

  task automatic pulse(input int zeros);
    logic [15:0] m;
    for (int i = 0; i < 8; i++) begin
      send(16'd4000, m);
      chk("mwi_rise", {16'd0, m}, 32'((i + 1) * 500));
    end
    for (int i = 0; i < zeros; i++) begin
      send(16'd0, m);
      chk("mwi_fall", {16'd0, m}, (i < 8) ? 32'(3500 - 500 * i) : 32'd0);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    in_valid = 1'b0;
    rstN     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic chk_peak(input int k, input logic [15:0] rr, input logic first);
    if (pk_amp.size() > k) begin
      chk("peak_amp", {16'd0, pk_amp[k]}, 32'd4000);
      chk("peak_rr", {16'd0, pk_rr[k]}, {16'd0, rr});
      chk("peak_first", {31'd0, pk_first[k]}, {31'd0, first});
      chk("peak_latency", {31'd0, pk_pre[k]}, 32'd1);
    end else begin
      chk("peak_missing", pk_amp.size(), k + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] m;
    rstN     = 1'b0;
    in_valid = 1'b0;
    y        = 16'sd0;
    thresh   = 16'd1000;
    @(negedge clk);
    chk("rst_mwi", {16'd0, mwi}, 32'd0);
    chk("rst_mwi_valid", {31'd0, mwi_valid}, 32'd0);
    chk("rst_peak_valid", {31'd0, peak_valid}, 32'd0);
    chk("rst_peak_amp", {16'd0, peak_amp}, 32'd0);
    chk("rst_rr", {16'd0, rr_interval}, 32'd0);
    chk("rst_first", {31'd0, first_peak}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Positive ramp to steady state, then drain.
    for (int i = 0; i < 12; i++) begin
      send(16'd800, m);
      chk("pos_ramp", {16'd0, m}, (i < 8) ? 32'((i + 1) * 100) : 32'd800);
    end
    for (int i = 0; i < 8; i++) begin
      send(16'd0, m);
      chk("pos_drain", {16'd0, m}, 32'(700 - 100 * i));
    end

    // Negative input rectifies identically; most-negative code saturates.
    for (int i = 0; i < 8; i++) begin
      send(16'hFCE0, m);
      chk("neg_ramp", {16'd0, m}, 32'((i + 1) * 100));
    end
    for (int i = 0; i < 8; i++) send(16'd0, m);
    chk("neg_drain", {16'd0, m}, 32'd0);
    thresh = 16'hFFFF;
    send(16'h8000, m);
    chk("sat_abs", {16'd0, m}, 32'd4095);
    for (int i = 0; i < 8; i++) begin
      send(16'd0, m);
      chk("sat_hold", {16'd0, m}, (i < 7) ? 32'd4095 : 32'd0);
    end
    chk("no_peak_yet", pk_amp.size(), 32'd0);
    thresh = 16'd1000;

    // A, B(+100), C(+150), D inside refractory (ignored), E(C+120).
    pulse(92);
    chk("peak_count_a", pk_amp.size(), 32'd1);
    chk_peak(0, 16'd0, 1'b1);
    pulse(142);
    pulse(18);
    pulse(86);
    pulse(60);
    @(negedge clk);
    in_valid = 1'b0;
    chk("peak_count_e", pk_amp.size(), 32'd4);
    chk_peak(1, 16'd100, 1'b0);
    chk_peak(2, 16'd150, 1'b0);
    chk_peak(3, 16'd120, 1'b0);
    chk("hold_amp", {16'd0, peak_amp}, 32'd4000);
    chk("hold_rr", {16'd0, rr_interval}, 32'd120);

    // Gapped stream gives the same values, stretched in time.
    reset_dut();
    gap_mode = 1'b1;
    pulse(20);
    gap_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("peak_count_gap", pk_amp.size(), 32'd5);
    chk_peak(4, 16'd0, 1'b1);

    // Reset while tracking discards the candidate.
    reset_dut();
    for (int i = 0; i < 5; i++) send(16'd4000, m);
    chk("pre_reset_mwi", {16'd0, m}, 32'd2500);
    @(negedge clk);
    in_valid = 1'b0;
    rstN     = 1'b0;
    #1;
    chk("mid_rst_mwi", {16'd0, mwi}, 32'd0);
    chk("mid_rst_peak_valid", {31'd0, peak_valid}, 32'd0);
    chk("mid_rst_peak_amp", {16'd0, peak_amp}, 32'd0);
    chk("mid_rst_rr", {16'd0, rr_interval}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) send(16'd0, m);
    chk("no_peak_after_rst", pk_amp.size(), 32'd5);
    pulse(20);
    @(negedge clk);
    in_valid = 1'b0;
    chk("peak_count_rst", pk_amp.size(), 32'd6);
    chk_peak(5, 16'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
